// File: rtl/tpu_ofmap_pkg.sv
// Shared OFMap buffer definitions: read-controller states, channel-group
// count and the (w, h, cg) -> buffer address layout used by writer and reader.
package tpu_ofmap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    function automatic int unsigned cg_count(input int unsigned ch, input int unsigned col);
        return ch / col;
    endfunction

    // Width innermost, then height, then channel group.
    function automatic int unsigned ofmap_addr(input int unsigned w, input int unsigned h,
                                               input int unsigned cg, input int unsigned cg_n,
                                               input int unsigned ow);
        return w * cg_n + h * cg_n * ow + cg;
    endfunction

endpackage

// File: rtl/ofmap_read_fifo.sv
// Two-entry skid FIFO holding SRAM read data plus its last-beat tag.
module ofmap_read_fifo #(
    parameter int unsigned WIDTH = 513
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;

    // Storage is cleared on reset so no stale beat is visible afterwards.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ofmap_read_controller.sv
// Walks a finished OFMap tile out of the buffer SRAM and streams it over
// valid/ready, absorbing the 1-cycle read latency in a 2-entry skid FIFO.
module ofmap_read_controller
    import tpu_ofmap_pkg::*;
#(
    parameter int unsigned MAC_COL           = 16,
    parameter int unsigned OFMAP_BITWIDTH    = 32,
    parameter int unsigned OFMAP_ADDR_BIT    = 10,
    parameter int unsigned OFMAP_CHANNEL_NUM = 64,
    parameter int unsigned OFMAP_WIDTH       = 14,
    parameter int unsigned OFMAP_HEIGHT      = 14
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start_in,
    output logic [OFMAP_ADDR_BIT-1:0]           ofmap_addr_out,
    output logic                                ofmap_read_en_out,
    input  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   ofmap_data_in,
    output logic [MAC_COL*OFMAP_BITWIDTH-1:0]   out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic                                busy_out,
    output logic                                ofmap_read_done_out
);

    localparam int unsigned CG  = cg_count(OFMAP_CHANNEL_NUM, MAC_COL);
    localparam int unsigned N   = OFMAP_WIDTH * OFMAP_HEIGHT * CG;
    localparam int unsigned DW  = MAC_COL * OFMAP_BITWIDTH;
    localparam int unsigned WW  = (OFMAP_WIDTH  > 1) ? $clog2(OFMAP_WIDTH)  : 1;
    localparam int unsigned HW  = (OFMAP_HEIGHT > 1) ? $clog2(OFMAP_HEIGHT) : 1;
    localparam int unsigned CGW = (CG > 1) ? $clog2(CG) : 1;
    localparam logic [WW-1:0]  W_MAX  = WW'(OFMAP_WIDTH - 1);
    localparam logic [HW-1:0]  H_MAX  = HW'(OFMAP_HEIGHT - 1);
    localparam logic [CGW-1:0] CG_MAX = CGW'(CG - 1);

    if (N > (2 ** OFMAP_ADDR_BIT)) begin : g_bad_addr_width
        $error("ofmap_read_controller: tile does not fit in OFMAP_ADDR_BIT address space");
    end
    if ((OFMAP_CHANNEL_NUM % MAC_COL) != 0) begin : g_bad_channel_num
        $error("ofmap_read_controller: OFMAP_CHANNEL_NUM must be a multiple of MAC_COL");
    end

    rd_state_e                 state;
    rd_state_e                 state_nxt;
    logic [WW-1:0]             w_q;
    logic [HW-1:0]             h_q;
    logic [CGW-1:0]            cg_q;
    logic [OFMAP_ADDR_BIT-1:0] addr_q;
    logic [OFMAP_ADDR_BIT-1:0] addr_c;
    logic                      inflight_q;
    logic                      last_tag_q;
    logic                      issue;
    logic                      clear_cnt;
    logic                      final_beat;
    logic                      pop;
    logic [1:0]                fifo_count;
    logic [DW:0]               fifo_rdata;

    assign final_beat = (w_q == W_MAX) && (h_q == H_MAX) && (cg_q == CG_MAX);
    assign addr_c     = OFMAP_ADDR_BIT'(ofmap_addr(32'(w_q), 32'(h_q), 32'(cg_q), CG, OFMAP_WIDTH));
    assign pop        = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue only while FIFO occupancy plus the in-flight read leaves room after this cycle's pop.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        clear_cnt = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_nxt = READ;
                    clear_cnt = 1'b1;
                end
            end
            READ: begin
                issue = (3'(fifo_count) + 3'(inflight_q) - 3'(pop)) < 3'd2;
                if (issue && final_beat) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((fifo_count == 2'(pop)) && !inflight_q) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // w innermost, then h, then channel group.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_q        <= '0;
            h_q        <= '0;
            cg_q       <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            last_tag_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            last_tag_q <= issue & final_beat;
            if (clear_cnt) begin
                w_q  <= '0;
                h_q  <= '0;
                cg_q <= '0;
            end else if (issue) begin
                addr_q <= addr_c;
                if (w_q != W_MAX) begin
                    w_q <= w_q + WW'(1);
                end else begin
                    w_q <= '0;
                    if (h_q != H_MAX) begin
                        h_q <= h_q + HW'(1);
                    end else begin
                        h_q  <= '0;
                        cg_q <= (cg_q == CG_MAX) ? '0 : cg_q + CGW'(1);
                    end
                end
            end
        end
    end

    ofmap_read_fifo #(
        .WIDTH (DW + 1)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (inflight_q),
        .pop   (pop),
        .wdata ({last_tag_q, ofmap_data_in}),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign ofmap_read_en_out   = issue;
    assign ofmap_addr_out      = issue ? addr_c : addr_q;
    assign out_valid           = (fifo_count != 2'd0);
    assign out_data            = fifo_rdata[DW-1:0];
    assign out_last            = out_valid & fifo_rdata[DW];
    assign busy_out            = (state != IDLE);
    assign ofmap_read_done_out = (state == DONE);

endmodule

// File: doc/ofmap_read_controller.md
# ofmap_read_controller

Reads a completed output-feature-map tile back out of the OFMap buffer SRAM and streams it over a valid/ready interface to the next consumer (host drain DMA or next-layer IFMap loader). It walks the buffer in the same nested order and address layout the OFMap write path uses: width innermost, then height, then channel group. It also absorbs the SRAM's fixed 1-cycle read latency and downstream backpressure in a 2-entry skid FIFO.

## Interface
- MAC_COL, 16, PE columns; channels per buffer word
- OFMAP_BITWIDTH, 32, bits per output element
- OFMAP_ADDR_BIT, 10, buffer address width
- OFMAP_CHANNEL_NUM, 64, output channels; must be a multiple of MAC_COL
- OFMAP_WIDTH, 14, ofmap width
- OFMAP_HEIGHT, 14, ofmap height
- Derived: CG = OFMAP_CHANNEL_NUM/MAC_COL; N = OFMAP_WIDTH*OFMAP_HEIGHT*CG; DW = MAC_COL*OFMAP_BITWIDTH
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- start_in  in  1  begin one tile read; sampled only in IDLE
- ofmap_addr_out  out  OFMAP_ADDR_BIT  SRAM read address
- ofmap_read_en_out  out  1  SRAM read strobe
- ofmap_data_in  in  DW  SRAM read data, valid the cycle after read_en
- out_data  out  DW  stream payload
- out_valid  out  1  payload valid
- out_ready  in  1  consumer accepts
- out_last  out  1  marks beat N-1
- busy_out  out  1  high outside IDLE
- ofmap_read_done_out  out  1  one-cycle pulse after last beat accepted

## Operation
- Address of beat (w,h,cg) = w*CG + h*CG*OFMAP_WIDTH + cg. The iteration order is w innermost, then h, then cg. Beat 0 is (0,0,0) and beat N-1 is (OW-1,OH-1,CG-1).
- The FSM has four states:
  - IDLE: start_in=1 moves to READ and clears the w/h/cg counters.
  - READ: issues reads, then moves to DRAIN in the cycle after the final read issues.
  - DRAIN: moves to DONE when the FIFO is empty and no read is in flight.
  - DONE: lasts one cycle, asserts ofmap_read_done_out, then returns to IDLE.
- Issue rule: in READ, ofmap_read_en_out = (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready.
  - inflight is 1 if a read was issued in the previous cycle.
  - Each issue advances the counters. w wraps at OW−1 and carries into h; h wraps at OH−1 and carries into cg.
- Push rule: data arriving the cycle after an issue is written into the FIFO unconditionally. The issue rule guarantees the FIFO never overflows.
- out_data/out_valid come from the FIFO head. out_last is a tag bit carried with each entry and is set on beat N−1.
- Once asserted, out_valid stays high and out_data stays stable until accepted.
- ofmap_addr_out is held at its last value when read_en is low.
- start_in is ignored outside IDLE.
- Arithmetic: all address terms are computed at OFMAP_ADDR_BIT width. N ≤ 2^OFMAP_ADDR_BIT is required (checked by an elaboration assertion).

## Timing
- Reset (rstn=0 at a rising edge) forces IDLE, clears the counters, FIFO, inflight and tags, and drives every output to 0. This holds when reset arrives mid-tile too; no partial beat survives.
- Latency: start_in sampled at edge k gives read_en high and address 0 during cycle k+1. The first out_valid appears in cycle k+3.
- Throughput: with out_ready held high, one beat per cycle; the last beat is accepted in cycle k+N+2.
- ofmap_read_done_out is high in the cycle after the last beat is accepted; busy_out drops the cycle after that.
- Backpressure: with out_ready low, at most 2 beats are buffered and issue stalls. When out_ready rises, beats resume with no bubbles after the first.
- A read issue and a pop in the same cycle are legal; the occupancy update is count + push − pop.

## Structure
- Shared package tpu_ofmap_pkg holds:
  - the state enum (IDLE, READ, DRAIN, DONE);
  - the function cg_count(ch, col);
  - the address function ofmap_addr(w, h, cg, CG, OW), so the writer and reader share one layout definition.
- Sub-module ofmap_read_fifo: 2-entry, DW+1 bits wide (data plus last), with sync reset and count output.
- Counters and FSM live in the top.

## Test plan
- OW=2, OH=2, CH=32, MAC_COL=16 (CG=2, N=8), out_ready=1, start at edge 0:
  - read addresses must be 0,2,4,6,1,3,5,7 in cycles 1–8;
  - out_valid must be high in cycles 3–10 with data equal to the SRAM model contents in that order;
  - out_last must be high on the 8th beat;
  - the done pulse must occur in cycle 11.
- Same config, out_ready low for cycles 0–20 then high: exactly 2 reads issue, the beat-0 payload stays stable, then all 8 beats arrive in order with no loss or duplication.
- Random out_ready (50%) on default parameters: 784 beats arrive in w/h/cg order; a scoreboard sees one done pulse and never more than 2 buffered beats.
- rstn low during cycle 5 of a tile: the next cycle shows all outputs 0 and state IDLE. A new start then produces a full, correct 8-beat sequence from address 0.
- start_in held high throughout and re-pulsed during READ/DRAIN: exactly one tile per IDLE entry and no counter restart mid-tile.
- Boundary: OW=1, OH=1, CG=1: a single beat at address 0 with out_last=1 and the done pulse in cycle 4.
